// File: rtl/wb_arbiter_pkg.sv
// Shared register-file types, load funct3 codes and the queue entry layout
// used by the write-back arbiter.
package wb_arbiter_pkg;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

  localparam reg_addr_bus_t ZERO_REG_ADDR = '0;
  localparam reg_bus_t      ZERO_WORD     = '0;
  localparam logic          ENABLE        = 1'b1;
  localparam logic          DISABLE       = 1'b0;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef struct packed {
    reg_addr_bus_t addr;
    reg_bus_t      data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_load_ext.sv
// Extracts the addressed byte/halfword from an aligned load word and
// sign- or zero-extends it; unknown funct3 codes pass the word through.
module wb_arbiter_load_ext
  import wb_arbiter_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] off,
  input  reg_bus_t   data,
  output reg_bus_t   data_out
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = data[{off, 3'b000} +: 8];
  assign half_sel = data[{off[1], 4'b0000} +: 16];

  always_comb begin
    data_out = data;
    case (funct3)
      FUNCT3_LB:  data_out = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: data_out = {24'd0, byte_sel};
      FUNCT3_LH:  data_out = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LHU: data_out = {16'd0, half_sel};
      default:    data_out = data;
    endcase
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU (A) and memory (B) results in program order
// through a small FIFO, drains one regfile write per cycle, tracks pending regs.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          a_valid,
  output logic          a_ready,
  input  reg_addr_bus_t a_addr,
  input  reg_bus_t      a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  reg_addr_bus_t b_addr,
  input  reg_bus_t      b_data,
  input  logic          b_is_load,
  input  logic [2:0]    b_funct3,
  input  logic [1:0]    b_off,
  output logic          w_enable,
  output reg_addr_bus_t w_addr,
  output reg_bus_t      w_data,
  input  reg_addr_bus_t q1_addr,
  input  reg_addr_bus_t q2_addr,
  output logic          q1_pending,
  output logic          q2_pending
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  wb_entry_t        fifo_mem [DEPTH];

  reg_bus_t  b_fmt, b_word;
  wb_entry_t a_ent, b_ent, head, first, second;
  logic      a_push, b_push, fifo_nonempty;
  logic      head_valid, first_valid, second_valid;
  logic [1:0] n_push;

  wb_arbiter_load_ext u_load_ext (
    .funct3   (b_funct3),
    .off      (b_off),
    .data     (b_data),
    .data_out (b_fmt)
  );

  // No pop lookahead: two free slots guarantee a dual push always fits.
  assign a_ready = !rst && (count_reg <= CNT_W'(DEPTH - 2));
  assign b_ready = a_ready;

  assign b_word        = b_is_load ? b_fmt : b_data;
  assign a_ent         = '{addr: a_addr, data: a_data};
  assign b_ent         = '{addr: b_addr, data: b_word};
  assign a_push        = rdy && a_valid && a_ready && (a_addr != ZERO_REG_ADDR);
  assign b_push        = rdy && b_valid && b_ready && (b_addr != ZERO_REG_ADDR);
  assign fifo_nonempty = (count_reg != '0);
  assign n_push        = {1'b0, first_valid} + {1'b0, second_valid};

  // Head of the logical queue (FIFO, then B, then A); leftovers get pushed.
  always_comb begin
    head_valid   = 1'b0;
    head         = '0;
    first_valid  = 1'b0;
    first        = '0;
    second_valid = 1'b0;
    second       = '0;
    if (fifo_nonempty) begin
      head_valid   = 1'b1;
      head         = fifo_mem[rd_ptr_reg];
      first_valid  = b_push || a_push;
      first        = b_push ? b_ent : a_ent;
      second_valid = b_push && a_push;
      second       = a_ent;
    end else if (b_push) begin
      head_valid  = 1'b1;
      head        = b_ent;
      first_valid = a_push;
      first       = a_ent;
    end else if (a_push) begin
      head_valid = 1'b1;
      head       = a_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (first_valid)
        fifo_mem[wr_ptr_reg] <= first;
      if (second_valid)
        fifo_mem[wr_ptr_reg + PTR_W'(1)] <= second;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      w_enable   <= DISABLE;
      w_addr     <= ZERO_REG_ADDR;
      w_data     <= ZERO_WORD;
    end else if (rdy) begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(n_push);
      if (fifo_nonempty)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(n_push) - CNT_W'(fifo_nonempty);
      w_enable  <= head_valid;
      if (head_valid) begin
        w_addr <= head.addr;
        w_data <= head.data;
      end
    end
  end

  logic [DEPTH-1:0] q1_hit, q2_hit;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
      logic [PTR_W-1:0] slot_off;
      logic             slot_live;
      assign slot_off   = PTR_W'(gi) - rd_ptr_reg;
      assign slot_live  = ({1'b0, slot_off} < count_reg);
      assign q1_hit[gi] = slot_live && (fifo_mem[gi].addr == q1_addr);
      assign q2_hit[gi] = slot_live && (fifo_mem[gi].addr == q2_addr);
    end
  endgenerate

  assign q1_pending = (q1_addr != ZERO_REG_ADDR) &&
                      ((|q1_hit) || (w_enable && (w_addr == q1_addr)));
  assign q2_pending = (q2_addr != ZERO_REG_ADDR) &&
                      ((|q2_hit) || (w_enable && (w_addr == q2_addr)));
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter feeding the register file write port (`w_enable`/`w_addr`/`w_data`), the initiator for that port. It accepts completed results from two pipeline sources in the same cycle: A is the ALU result and B is the memory/load result. Load data is formatted by byte offset and sign rule, results are queued in program order (B older than A), and one write per cycle is drained to the register file. It also reports which architectural registers still have writes in flight, for decode-stage hazard checks.

## Interface
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rdy`  in  1  global ready; when `Disable`, all state freezes
- `a_valid`  in  1  ALU result valid
- `a_ready`  out  1  source A may present
- `a_addr`  in  `RegAddrBus`  destination register
- `a_data`  in  `RegBus`  result
- `b_valid`  in  1  memory-stage result valid
- `b_ready`  out  1  source B may present
- `b_addr`  in  `RegAddrBus`  destination register
- `b_data`  in  `RegBus`  raw aligned memory word, or non-load result
- `b_is_load`  in  1  apply load formatting to `b_data`
- `b_funct3`  in  3  LB/LH/LW/LBU/LHU
- `b_off`  in  2  byte offset of the access
- `w_enable`  out  1  regfile write enable (registered)
- `w_addr`  out  `RegAddrBus`  regfile write address (registered)
- `w_data`  out  `RegBus`  regfile write data (registered)
- `q1_addr`, `q2_addr`  in  `RegAddrBus`  pending-write query
- `q1_pending`, `q2_pending`  out  1  query address has a write in flight

## Operation
- **Transfers.** A transfer occurs on a posedge with `rst` low, `rdy` high and `x_valid && x_ready`. Data on an input while it is not ready is ignored.
- **Writes to x0.** A transfer with `addr == ZeroRegAddr` is accepted and then discarded. It is never queued or written.
- **Logical queue.** Order is the FIFO contents, then incoming B, then incoming A. On each enabled edge:
  - If the logical queue is non-empty, its head is loaded into `w_*` with `w_enable = 1`. Remaining incoming entries are pushed in order.
  - If the logical queue is empty, `w_enable` goes to 0. `w_addr` and `w_data` hold their values.
- **Ready rule.** `a_ready = b_ready = !rst && (DEPTH - count >= 2)`, where `count` is the registered FIFO occupancy. There is no pop lookahead, so two simultaneous pushes are always safe.
- **Load formatting** (applied when `b_is_load`, before queuing):
  - LB / LBU: byte `b_data[8*b_off +: 8]`, sign- or zero-extended.
  - LH / LHU: halfword `b_data[16*b_off[1] +: 16]`, sign- or zero-extended. `b_off[0]` is ignored.
  - LW: `b_data` unchanged.
  - Other funct3 values: `b_data` unchanged.
- **Pending query.** `qN_pending = 1` iff `qN_addr != 0` and `qN_addr` matches any valid FIFO entry, or matches `w_addr` while `w_enable = 1`. Combinational from registered state only; same-cycle inputs are not included.
- **Same destination twice.** Both entries are kept and drain in order, so the younger value (A) wins in the regfile.
- **`rdy` low.** No transfer, no pop; `w_*` and the FIFO hold. The regfile ignores the held write because it gates writes on `rdy`.
- **Reset.** `count = 0`, pointers cleared, `w_enable = 0`, `w_addr = 0`, `w_data = 0`, `qN_pending = 0`. In-flight entries are dropped, including a mid-drain queue.

## Timing
- A result transferred at edge t appears on `w_*` after edge t, if it is the logical-queue head. The regfile commits it at edge t+1.
- Minimum latency is 1 cycle. Each entry ahead of it adds 1 cycle.
- Throughput is 1 write per cycle. Sustained dual-issue fills the FIFO, and `ready` drops once fewer than 2 slots are free.
- `ready` is high in the first cycle after `rst` deasserts.
- Full / empty:
  - `count == DEPTH` is unreachable by the ready rule. Maximum occupancy is `DEPTH - 1` after a push of two with a simultaneous pop.
  - When the FIFO is empty with no input, `w_enable = 0` on the next edge.
- Pointers wrap modulo `DEPTH`.

## Structure
- `config.v`: load funct3 codes `LB 3'b000`, `LH 3'b001`, `LW 3'b010`, `LBU 3'b100`, `LHU 3'b101`. Reuse the existing `RegBus`, `RegAddrBus`, `ZeroRegAddr`, `ZeroWord`, `Enable`/`Disable`.
- Sub-module `load_ext`: combinational, takes `funct3`, `off` and `data`, returns the formatted word.
- FIFO storage, pointers, occupancy count and the pending compare live in `wb_arbiter`.

## Test plan
- **Single write.** A: `addr=5`, `data=0x1234` → `w_enable=1`, `w_addr=5`, `w_data=0x1234` one cycle later, then `w_enable=0`.
- **Simultaneous sources.** Same cycle, B `(addr=3, 0xAA)` and A `(addr=3, 0xBB)` → writes `(3, 0xAA)` then `(3, 0xBB)` on consecutive cycles. `q1_addr=3` is pending for 2 cycles.
- **Load formatting.** B load of `0x80FF7F01`:
  - LB off=3 → `0xFFFFFF80`
  - LBU off=3 → `0x00000080`
  - LH off=2 → `0xFFFF80FF`
  - LHU off=0 → `0x00007F01`
  - LW → `0x80FF7F01`
- **Backpressure.** `DEPTH=4`, both sources valid every cycle → ready drops once occupancy ≥ 3. No entry is lost or reordered over 20 transfers, and writes are continuous.
- **x0 and `rdy`.**
  - A write to x0 produces no `w_enable` pulse, and `q1_addr=0` always reads 0.
  - Holding `rdy` low for 3 cycles mid-drain freezes `w_*`. Draining resumes in order afterwards.
- **Reset mid-drain.** With 3 entries queued, assert `rst` for 1 cycle → `w_enable=0`, `count=0`, all pending flags 0. No stale write appears afterwards.
